// File: rtl/packet_lane_dispatcher.sv
`default_nettype none
// ============================================================================
// Module   : packet_lane_dispatcher
// Purpose  : Sends whole AXI-Stream packets to the least-loaded of NUM_LANES
//            processing lanes. An order FIFO of lane ids collects the lane
//            results back into the original packet order.
// Ports    : axis_aclk/axis_reset     - clock, asynchronous active-high reset
//            s_axis_*                 - ingress packet stream
//            lane_out_axis_*          - flattened per-lane egress (slice i = lane i)
//            lane_in_axis_*           - flattened per-lane results
//            m_axis_*                 - in-order egress stream (registered)
//            order_count              - packets dispatched but not yet collected
// Revision : 1.0 - initial release
// ============================================================================
module packet_lane_dispatcher #(
  parameter int TDATA_WIDTH = 256,
  parameter int TUSER_WIDTH = 128,
  parameter int NUM_LANES   = 4,
  parameter int ORDER_DEPTH = 8,
  localparam int TKEEP_WIDTH = TDATA_WIDTH / 8,
  localparam int LANE_W      = $clog2(NUM_LANES),
  localparam int CNT_W       = $clog2(ORDER_DEPTH) + 1
) (
  input  logic                             axis_aclk,
  input  logic                             axis_reset,
  input  logic [TDATA_WIDTH-1:0]           s_axis_tdata,
  input  logic [TKEEP_WIDTH-1:0]           s_axis_tkeep,
  input  logic [TUSER_WIDTH-1:0]           s_axis_tuser,
  input  logic                             s_axis_tvalid,
  input  logic                             s_axis_tlast,
  output logic                             s_axis_tready,
  output logic [NUM_LANES*TDATA_WIDTH-1:0] lane_out_axis_tdata,
  output logic [NUM_LANES*TKEEP_WIDTH-1:0] lane_out_axis_tkeep,
  output logic [NUM_LANES*TUSER_WIDTH-1:0] lane_out_axis_tuser,
  output logic [NUM_LANES-1:0]             lane_out_axis_tvalid,
  output logic [NUM_LANES-1:0]             lane_out_axis_tlast,
  input  logic [NUM_LANES-1:0]             lane_out_axis_tready,
  input  logic [NUM_LANES*TDATA_WIDTH-1:0] lane_in_axis_tdata,
  input  logic [NUM_LANES*TKEEP_WIDTH-1:0] lane_in_axis_tkeep,
  input  logic [NUM_LANES*TUSER_WIDTH-1:0] lane_in_axis_tuser,
  input  logic [NUM_LANES-1:0]             lane_in_axis_tvalid,
  input  logic [NUM_LANES-1:0]             lane_in_axis_tlast,
  output logic [NUM_LANES-1:0]             lane_in_axis_tready,
  output logic [TDATA_WIDTH-1:0]           m_axis_tdata,
  output logic [TKEEP_WIDTH-1:0]           m_axis_tkeep,
  output logic [TUSER_WIDTH-1:0]           m_axis_tuser,
  output logic                             m_axis_tvalid,
  output logic                             m_axis_tlast,
  input  logic                             m_axis_tready,
  output logic [CNT_W-1:0]                 order_count
);

  localparam int PTR_W = $clog2(ORDER_DEPTH);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t                 state_q, state_d;
  logic [LANE_W-1:0]      cur_lane_q, cur_lane_d;
  logic [LANE_W-1:0]      order_mem_q [ORDER_DEPTH];
  logic [LANE_W-1:0]      order_mem_d [ORDER_DEPTH];
  logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]       count_q, count_d;
  logic [CNT_W-1:0]       outstanding_q [NUM_LANES];
  logic [CNT_W-1:0]       outstanding_d [NUM_LANES];
  logic                   m_valid_q, m_valid_d;
  logic [TDATA_WIDTH-1:0] m_data_q, m_data_d;
  logic [TKEEP_WIDTH-1:0] m_keep_q, m_keep_d;
  logic [TUSER_WIDTH-1:0] m_user_q, m_user_d;
  logic                   m_last_q, m_last_d;

  logic [TDATA_WIDTH-1:0] lane_in_data [NUM_LANES];
  logic [TKEEP_WIDTH-1:0] lane_in_keep [NUM_LANES];
  logic [TUSER_WIDTH-1:0] lane_in_user [NUM_LANES];

  logic [LANE_W-1:0]      best_lane;
  logic [CNT_W-1:0]       best_cnt;
  logic [LANE_W-1:0]      target;
  logic [LANE_W-1:0]      head_lane;
  logic                   fifo_full, fifo_empty;
  logic                   in_hs, push, pop;
  logic                   out_ready, collect_en, lane_hs;

  // Least-loaded lane; strict less-than keeps ties on the lowest index.
  always_comb begin
    best_lane = '0;
    best_cnt  = outstanding_q[0];
    for (int i = 1; i < NUM_LANES; i++) begin
      if (outstanding_q[i] < best_cnt) begin
        best_cnt  = outstanding_q[i];
        best_lane = LANE_W'(i);
      end
    end
  end

  assign target        = (state_q == SEND) ? cur_lane_q : best_lane;
  assign fifo_full     = (count_q == CNT_W'(ORDER_DEPTH));
  assign fifo_empty    = (count_q == '0);
  // Valid follows the target alone; acceptance also needs order-FIFO space
  // for a first beat.
  assign s_axis_tready = lane_out_axis_tready[target] & ((state_q == SEND) | ~fifo_full);
  assign in_hs         = s_axis_tvalid & s_axis_tready;
  assign push          = in_hs & (state_q == IDLE);

  assign head_lane  = order_mem_q[rd_ptr_q];
  assign out_ready  = ~m_valid_q | m_axis_tready;
  assign collect_en = ~fifo_empty & out_ready;
  assign lane_hs    = collect_en & lane_in_axis_tvalid[head_lane];
  assign pop        = lane_hs & lane_in_axis_tlast[head_lane];

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    assign lane_out_axis_tdata[g*TDATA_WIDTH +: TDATA_WIDTH] = s_axis_tdata;
    assign lane_out_axis_tkeep[g*TKEEP_WIDTH +: TKEEP_WIDTH] = s_axis_tkeep;
    assign lane_out_axis_tuser[g*TUSER_WIDTH +: TUSER_WIDTH] = s_axis_tuser;
    assign lane_out_axis_tlast[g]  = s_axis_tlast;
    assign lane_out_axis_tvalid[g] = s_axis_tvalid & (target == LANE_W'(g));
    assign lane_in_axis_tready[g]  = collect_en & (head_lane == LANE_W'(g));
    assign lane_in_data[g] = lane_in_axis_tdata[g*TDATA_WIDTH +: TDATA_WIDTH];
    assign lane_in_keep[g] = lane_in_axis_tkeep[g*TKEEP_WIDTH +: TKEEP_WIDTH];
    assign lane_in_user[g] = lane_in_axis_tuser[g*TUSER_WIDTH +: TUSER_WIDTH];
  end

  // Dispatcher FSM: single-beat packets never leave IDLE.
  always_comb begin
    state_d    = state_q;
    cur_lane_d = cur_lane_q;
    case (state_q)
      IDLE: begin
        if (push && !s_axis_tlast) begin
          state_d    = SEND;
          cur_lane_d = target;
        end
      end
      SEND: begin
        if (in_hs && s_axis_tlast) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Order FIFO, occupancy and per-lane outstanding counters.
  always_comb begin
    order_mem_d = order_mem_q;
    if (push) begin
      order_mem_d[wr_ptr_q] = target;
    end
    wr_ptr_d = wr_ptr_q + PTR_W'(push);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop);
    count_d  = count_q;
    if (push && !pop) begin
      count_d = count_q + CNT_W'(1);
    end else if (pop && !push) begin
      count_d = count_q - CNT_W'(1);
    end
    for (int i = 0; i < NUM_LANES; i++) begin
      outstanding_d[i] = outstanding_q[i];
      if ((push && target == LANE_W'(i)) && !(pop && head_lane == LANE_W'(i))) begin
        outstanding_d[i] = outstanding_q[i] + CNT_W'(1);
      end else if ((pop && head_lane == LANE_W'(i)) && !(push && target == LANE_W'(i))) begin
        outstanding_d[i] = outstanding_q[i] - CNT_W'(1);
      end
    end
  end

  // One-deep output register; reloads in the same cycle it drains.
  always_comb begin
    m_valid_d = m_valid_q;
    m_data_d  = m_data_q;
    m_keep_d  = m_keep_q;
    m_user_d  = m_user_q;
    m_last_d  = m_last_q;
    if (lane_hs) begin
      m_valid_d = 1'b1;
      m_data_d  = lane_in_data[head_lane];
      m_keep_d  = lane_in_keep[head_lane];
      m_user_d  = lane_in_user[head_lane];
      m_last_d  = lane_in_axis_tlast[head_lane];
    end else if (m_axis_tready) begin
      m_valid_d = 1'b0;
    end
  end

  always_ff @(posedge axis_aclk or posedge axis_reset) begin
    if (axis_reset) begin
      state_q    <= IDLE;
      cur_lane_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      for (int i = 0; i < ORDER_DEPTH; i++) order_mem_q[i] <= '0;
      for (int i = 0; i < NUM_LANES; i++) outstanding_q[i] <= '0;
      m_valid_q  <= 1'b0;
      m_data_q   <= '0;
      m_keep_q   <= '0;
      m_user_q   <= '0;
      m_last_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      cur_lane_q    <= cur_lane_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      order_mem_q   <= order_mem_d;
      outstanding_q <= outstanding_d;
      m_valid_q     <= m_valid_d;
      m_data_q      <= m_data_d;
      m_keep_q      <= m_keep_d;
      m_user_q      <= m_user_d;
      m_last_q      <= m_last_d;
    end
  end

  assign m_axis_tvalid = m_valid_q;
  assign m_axis_tdata  = m_data_q;
  assign m_axis_tkeep  = m_keep_q;
  assign m_axis_tuser  = m_user_q;
  assign m_axis_tlast  = m_last_q;
  assign order_count   = count_q;

endmodule
`default_nettype wire

// File: doc/packet_lane_dispatcher.md
# packet_lane_dispatcher

Scales the parse → process → pack packet pipeline by distributing whole packets across NUM_LANES parallel processing lanes and recombining their results in arrival order. Sits between the packet parser (per-packet metadata carried in tuser) and the packet packer. Each arriving packet goes to the least-loaded lane. An order FIFO guarantees that output packets leave in the same order they entered, regardless of per-lane latency.

## Interface
- TDATA_WIDTH, 256, AXIS data width; TKEEP_WIDTH = TDATA_WIDTH/8 (derived).
- TUSER_WIDTH, 128, AXIS user width; carries per-packet metadata, passed through unmodified.
- NUM_LANES, 4, number of processing lanes; 2..8.
- ORDER_DEPTH, 8, order FIFO depth in packets; power of two, ≥ NUM_LANES.
- axis_aclk  in  1  the single clock; all logic is on its rising edge.
- axis_reset  in  1  asynchronous, active-high reset.
- s_axis_tdata/tkeep/tuser/tvalid/tlast  in  TDATA/TKEEP/TUSER/1/1  ingress packet stream.
- s_axis_tready  out  1  ingress ready.
- lane_out_axis_tdata/tkeep/tuser  out  NUM_LANES×TDATA/TKEEP/TUSER  flattened per-lane egress to the processors; lane i occupies slice i.
- lane_out_axis_tvalid/tlast  out  NUM_LANES each  per-lane egress valid and last.
- lane_out_axis_tready  in  NUM_LANES  per-lane egress ready.
- lane_in_axis_tdata/tkeep/tuser  in  NUM_LANES×TDATA/TKEEP/TUSER  per-lane results returned from the processors.
- lane_in_axis_tvalid/tlast  in  NUM_LANES each  per-lane result valid and last.
- lane_in_axis_tready  out  NUM_LANES  per-lane result ready.
- m_axis_tdata/tkeep/tuser/tvalid/tlast  out  TDATA/TKEEP/TUSER/1/1  egress stream to the packer.
- m_axis_tready  in  1  egress ready.
- order_count  out  clog2(ORDER_DEPTH)+1  number of packets in flight (dispatched but not yet fully collected).

## Operation
- **Dispatcher FSM:**
  - States: IDLE (between packets) and SEND (mid-packet, lane locked in `cur_lane`).
  - In IDLE, the target lane is the one with the smallest outstanding counter; ties go to the lowest index.
  - The target is evaluated every cycle and is locked on the first-beat handshake. IDLE→SEND occurs on a first beat with tlast=0.
  - A single-beat packet (tlast=1 on the first beat) stays in IDLE but is still counted and recorded.
  - SEND→IDLE occurs on the tlast handshake.
- **Dispatcher datapath:**
  - Combinational pass-through. s_axis data/tuser/tkeep/tlast fan out to every lane slice.
  - lane_out_axis_tvalid[i] = s_axis_tvalid & (i == target).
  - s_axis_tready = lane_out_axis_tready[target] & (state==SEND | order FIFO not full).
- **First-beat handshake:** pushes the target lane id into the order FIFO and increments outstanding[target].
- **Collector:**
  - The head of the order FIFO selects lane h. Only lane_in_axis_tready[h] may be high, and only when the FIFO is non-empty and the output register can accept a beat. All other lanes' tready are 0.
  - Beats move into a one-deep output register.
  - On the lane h tlast handshake: pop the FIFO and decrement outstanding[h].
- **Outstanding counters:** width clog2(ORDER_DEPTH)+1. A simultaneous increment and decrement on the same lane leaves the counter unchanged. A counter never exceeds ORDER_DEPTH, because the FIFO bounds the total number of packets in flight.
- **Order FIFO:** ORDER_DEPTH × clog2(NUM_LANES) bits. Read and write pointers wrap modulo ORDER_DEPTH. Simultaneous push and pop while full is not allowed, because the push is gated by "not full". Simultaneous push and pop while empty-to-one is legal.
- **order_count:** equals the FIFO occupancy, updated in the same cycle as each push or pop.
- **Reset** (at any time, including mid-packet):
  - FIFO empty, all counters 0, state IDLE.
  - m_axis_tvalid=0; m_axis_tdata/tkeep/tuser/tlast=0.
  - order_count=0; all lane_in_axis_tready=0.
  - Partial packets are discarded. The lanes must be reset in the same cycle.

## Timing
- Dispatch latency is 0 cycles (combinational from s_axis to lane_out).
- Collect latency is 1 cycle: a lane beat accepted at edge N is presented on m_axis after edge N.
- Output register:
  - It accepts a new beat when it is empty or when m_axis_tready=1 in the same cycle, giving full throughput of 1 beat per cycle.
  - m_axis_tvalid is held until the handshake; data is stable while valid & !ready.
- A lane selected in IDLE whose tready is low stalls ingress. The dispatcher does not re-arbitrate to another lane in the same cycle, except that the target recomputes if the outstanding counters change.
- When the FIFO is full, s_axis_tready is 0 in IDLE. A pop in cycle N allows a first beat to be accepted in cycle N+1.

## Test plan
- **Single lane busy:** NUM_LANES=4. Send 4 packets of 3 beats each with all lanes ready and lanes holding results. Packets go to lanes 0,1,2,3, and order_count reaches 4.
- **Reordering:** lane 1 returns its packet before lane 0. m_axis still emits packet 0 first; lane_in_axis_tready[1] stays 0 until packet 0's tlast has left.
- **Full FIFO:** ORDER_DEPTH=8 with no lane returning data. Exactly 8 packets are accepted. For the 9th packet's first beat, s_axis_tready=0 until one packet is collected, then it is accepted on the next cycle.
- **Single-beat packets back-to-back:** 16 packets with tlast=1, with m_axis_tready=1. Output is 16 beats in order, with no bubbles after the first cycle of latency.
- **Tie-break and balance:** lane 2 has outstanding=0 and the others have 1. The next packet goes to lane 2. When all counters are equal, the next packet goes to lane 0.
- **Reset mid-packet:** assert axis_reset during beat 2 of 4. After release, order_count=0, m_axis_tvalid=0, and the next packet goes to lane 0.
